// File: rtl/dot_matrix_pkg.sv
// Shared types and sizing helpers for the 8x8 dot-matrix row-scan controller.
package dot_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    localparam int BRIGHT_W = 3;

    // Index width for n entries, never below one bit.
    function automatic int row_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dot_matrix_frame_buf.sv
// Double-buffered ROWSxCOLS frame store: one write port into the back bank,
// one combinational read port from the front bank, bank roles flip on swap.
module dot_matrix_frame_buf
    import dot_matrix_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int ROW_W = row_w(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic             swap,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data
);

    logic             front_sel_reg;
    logic [COLS-1:0]  bank0_rd [ROWS];
    logic [COLS-1:0]  bank1_rd [ROWS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel_reg <= 1'b0;
        end else if (swap) begin
            front_sel_reg <= ~front_sel_reg;
        end
    end

    // The write targets whichever bank is back before this edge, so a write
    // coincident with a swap lands in the bank that becomes front.
    // Out-of-range row addresses match no row and are dropped.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [COLS-1:0] b0_reg;
            logic [COLS-1:0] b1_reg;
            logic            hit;

            assign hit = wr_en && (wr_row == ROW_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b0_reg <= '0;
                    b1_reg <= '0;
                end else if (hit) begin
                    if (front_sel_reg) begin
                        b0_reg <= wr_data;
                    end else begin
                        b1_reg <= wr_data;
                    end
                end
            end

            assign bank0_rd[gi] = b0_reg;
            assign bank1_rd[gi] = b1_reg;
        end
    endgenerate

    assign rd_data = front_sel_reg ? bank1_rd[rd_row] : bank0_rd[rd_row];

endmodule

// File: rtl/dot_matrix_scan_ctrl.sv
// Row-scan sequencer for the LED dot matrix with a tear-free double-buffered frame.
// Define DOT_MATRIX_BRIGHTNESS_EN to add a brightness input that PWM-gates the columns.
module dot_matrix_scan_ctrl
    import dot_matrix_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int COLS           = DEF_COLS,
    parameter int DRIVE_TICKS    = 4,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0,
    parameter int ROW_W          = row_w(ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_tick,
    input  logic                en,
    input  logic                wr_en,
    input  logic [ROW_W-1:0]    wr_row,
    input  logic [COLS-1:0]     wr_data,
    input  logic                swap_req,
`ifdef DOT_MATRIX_BRIGHTNESS_EN
    input  logic [BRIGHT_W-1:0] brightness,
`endif
    output logic                swap_ack,
    output logic [ROWS-1:0]     row_out,
    output logic [COLS-1:0]     col_out,
    output logic                frame_start
);

    localparam int TICK_W = row_w(DRIVE_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DRIVE_TICKS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROWS-1:0]   ROW_INACT = ROW_ACTIVE_LOW ? {ROWS{1'b1}} : {ROWS{1'b0}};
    localparam logic [COLS-1:0]   COL_INACT = COL_ACTIVE_LOW ? {COLS{1'b1}} : {COLS{1'b0}};

    scan_state_t        state_reg, state_next;
    logic [ROW_W-1:0]   row_idx_reg, row_idx_next;
    logic [TICK_W-1:0]  tick_cnt_reg, tick_cnt_next;
    logic [ROWS-1:0]    row_out_reg, row_out_next;
    logic [COLS-1:0]    col_out_reg, col_out_next;
    logic               swap_ack_reg, swap_ack_next;
    logic               frame_start_reg, frame_start_next;

    logic               swap_now;
    logic               drive_now;
    logic               col_lit;
    logic [ROWS-1:0]    row_sel;
    logic [COLS-1:0]    front_data;

    dot_matrix_frame_buf #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W)
    ) u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .swap    (swap_now),
        .rd_row  (row_idx_reg),
        .rd_data (front_data)
    );

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_sel
            assign row_sel[gi] = (row_idx_reg == ROW_W'(gi));
        end
    endgenerate

`ifdef DOT_MATRIX_BRIGHTNESS_EN
    logic [BRIGHT_W-1:0] pwm_cnt_reg;
    logic [BRIGHT_W-1:0] pwm_cnt_next;

    assign pwm_cnt_next = pwm_cnt_reg + 1'b1;
    // Gate against the count the output register will sit alongside.
    assign col_lit      = (pwm_cnt_next <= brightness);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_next;
        end
    end
`else
    assign col_lit = 1'b1;
`endif

    always_comb begin
        state_next       = state_reg;
        row_idx_next     = row_idx_reg;
        tick_cnt_next    = tick_cnt_reg;
        frame_start_next = 1'b0;
        drive_now        = 1'b0;
        // The IDLE swap waits for the previous ack to clear, so the requester sees it.
        swap_now         = (state_reg == IDLE) && swap_req && !swap_ack_reg;

        if (!en) begin
            state_next    = IDLE;
            row_idx_next  = '0;
            tick_cnt_next = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    state_next = BLANK;
                end
                BLANK: begin
                    if (scan_tick) begin
                        state_next       = DRIVE;
                        tick_cnt_next    = '0;
                        drive_now        = 1'b1;
                        frame_start_next = (row_idx_reg == '0);
                    end
                end
                DRIVE: begin
                    drive_now = 1'b1;
                    if (scan_tick) begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            state_next    = BLANK;
                            tick_cnt_next = '0;
                            drive_now     = 1'b0;
                            if (row_idx_reg == ROW_LAST) begin
                                row_idx_next = '0;
                                swap_now     = swap_req;
                            end else begin
                                row_idx_next = row_idx_reg + 1'b1;
                            end
                        end else begin
                            tick_cnt_next = tick_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        swap_ack_next = swap_now;
        row_out_next  = ROW_INACT;
        col_out_next  = COL_INACT;
        if (drive_now) begin
            row_out_next = row_sel ^ ROW_INACT;
            col_out_next = col_lit ? (front_data ^ COL_INACT) : COL_INACT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            row_idx_reg     <= '0;
            tick_cnt_reg    <= '0;
            row_out_reg     <= ROW_INACT;
            col_out_reg     <= COL_INACT;
            swap_ack_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            row_idx_reg     <= row_idx_next;
            tick_cnt_reg    <= tick_cnt_next;
            row_out_reg     <= row_out_next;
            col_out_reg     <= col_out_next;
            swap_ack_reg    <= swap_ack_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign row_out     = row_out_reg;
    assign col_out     = col_out_reg;
    assign swap_ack    = swap_ack_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Directed bench for dot_matrix_scan_ctrl: reset, scan order, frame-boundary swap,
// back-bank writes, enable drop/resume, and brightness gating when enabled.
module tb_dot_matrix_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_tick;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       swap_req;
    logic       swap_ack;
    logic [7:0] row_out;
    logic [7:0] col_out;
    logic       frame_start;
`ifdef DOT_MATRIX_BRIGHTNESS_EN
    logic [2:0] brightness;
`endif

    int n_vec    = 0;
    int n_miscmp = 0;

    dot_matrix_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .scan_tick   (scan_tick),
        .en          (en),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
`ifdef DOT_MATRIX_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .swap_ack    (swap_ack),
        .row_out     (row_out),
        .col_out     (col_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] new_val(input int r);
        logic [7:0] v;
        v = (r == 2) ? 8'h5A : (8'h80 | 8'(r));
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_row;
        logic [7:0] exp_col;
        int         f, p, r, lit;

        rst = 1'b1; scan_tick = 1'b0; en = 1'b0; wr_en = 1'b0;
        wr_row = '0; wr_data = '0; swap_req = 1'b0;
`ifdef DOT_MATRIX_BRIGHTNESS_EN
        brightness = 3'd7;
`endif
        step();
        chk("rst_row", 32'(row_out), 32'hFF);
        chk("rst_col", 32'(col_out), 32'h00);
        step();
        rst = 1'b0;

        // Idle with en=0 stays blank.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_row", 32'(row_out), 32'hFF);
            chk("idle_col", 32'(col_out), 32'h00);
            chk("idle_ack", 32'(swap_ack), 32'h0);
            chk("idle_fs", 32'(frame_start), 32'h0);
        end

        // Load back bank with a walking one.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_row = 3'(i); wr_data = 8'h01 << i;
            step();
            $display("write row %0d data %02h", i, wr_data);
        end
        wr_en = 1'b0;

        // Held request in IDLE: ack every other clock, three swaps in five clocks.
        swap_req = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("idle_swap_ack", 32'(swap_ack), 32'((s % 2) == 0));
            $display("idle swap clk %0d ack %0b", s, swap_ack);
        end
        swap_req = 1'b0;
        step();
        chk("idle_swap_drop", 32'(swap_ack), 32'h0);

        en = 1'b1;
        step();
        chk("blank_row", 32'(row_out), 32'hFF);
        chk("blank_col", 32'(col_out), 32'h00);

        for (int t = 1; t <= 147; t++) begin
            scan_tick = 1'b1;
            step();
            scan_tick = 1'b0;
            f = (t - 1) / 40;
            p = (t - 1) % 5;
            r = ((t - 1) % 40) / 5;
            exp_row = (p < 4) ? ~(8'h01 << r) : 8'hFF;
            exp_col = (p < 4) ? ((f >= 2) ? new_val(r) : (8'h01 << r)) : 8'h00;
            chk("scan_row", 32'(row_out), 32'(exp_row));
            chk("scan_col", 32'(col_out), 32'(exp_col));
            chk("scan_fs", 32'(frame_start), 32'(((t - 1) % 40) == 0));
            chk("scan_ack", 32'(swap_ack), 32'(t == 80));
            $display("tick %0d row_out %02h col_out %02h fs %0b ack %0b",
                     t, row_out, col_out, frame_start, swap_ack);
            if (t == 80) swap_req = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (k == 0 && t >= 12 && t <= 19) begin
                    wr_en = 1'b1; wr_row = 3'(t - 12); wr_data = new_val(t - 12);
                end
                if (k == 0 && t == 56) swap_req = 1'b1;
                step();
                wr_en = 1'b0;
                chk("gap_ack", 32'(swap_ack), 32'h0);
            end
            chk("hold_row", 32'(row_out), 32'(exp_row));
            chk("hold_col", 32'(col_out), 32'(exp_col));
        end

        // Drop enable while driving row 5.
        en = 1'b0;
        step();
        chk("endrop_row", 32'(row_out), 32'hFF);
        chk("endrop_col", 32'(col_out), 32'h00);
        $display("en drop row_out %02h col_out %02h", row_out, col_out);
        step();
        step();
        en = 1'b1;
        step();
        chk("resume_blank_row", 32'(row_out), 32'hFF);
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        chk("resume_row", 32'(row_out), 32'hFE);
        chk("resume_col", 32'(col_out), 32'h80);
        chk("resume_fs", 32'(frame_start), 32'h1);
        $display("resume row_out %02h col_out %02h fs %0b", row_out, col_out, frame_start);

`ifdef DOT_MATRIX_BRIGHTNESS_EN
        brightness = 3'd3;
        step();
        lit = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (col_out == 8'h80) lit++;
        end
        chk("pwm_lit", 32'(lit), 32'd4);
        $display("brightness 3 lit clocks %0d of 8", lit);
`else
        lit = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (col_out == 8'h80) lit++;
        end
        chk("ungated_lit", 32'(lit), 32'd8);
        $display("ungated lit clocks %0d of 8", lit);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
